// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains bytes from an 8-bit synchronous FIFO (rd/empty/datao interface with
//   registered datao) and serialises each one onto an asynchronous-serial line:
//   1 start bit, 8 data bits LSB first, optional even-parity bit, 1 stop bit.
//   Single clock domain, asynchronous active-high reset.
//
//   Build option: define PARITY_EN to insert an even-parity bit between the
//   last data bit and the stop bit (11-bit frames instead of 10).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..255)
//   DATA_W        FIFO data width (fixed at 8)
//
// Ports
//   clk        system clock, rising-edge active
//   res        asynchronous active-high reset
//   tx_en      permits new FIFO fetches; a frame in progress always completes
//   empty      FIFO empty flag, sampled only while idle
//   fifo_data  FIFO datao, valid the cycle after rd is sampled
//   rd         FIFO read strobe, registered one-cycle pulse
//   txd        serial output, registered, idle high
//   busy       high whenever the transmitter is not idle
//   frame_cnt  completed-frame counter, wraps 255 -> 0
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic              tx_en,
  input  logic              empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              rd,
  output logic              txd,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_START,
    S_DATA,
`ifdef PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud;
  logic [2:0]          r_bit_idx;
  logic [DATA_W-1:0]   r_shift;
  logic                r_txd;
  logic                r_rd;
  logic [7:0]          r_frame_cnt;
`ifdef PARITY_EN
  logic                r_parity;
  logic                w_parity_nxt;
`endif

  state_t              w_state_nxt;
  logic [BAUD_W-1:0]   w_baud_nxt;
  logic [2:0]          w_bit_idx_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_txd_nxt;
  logic                w_rd_nxt;
  logic [7:0]          w_frame_cnt_nxt;
  logic                w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_txd       <= 1'b1;
      r_rd        <= 1'b0;
      r_frame_cnt <= '0;
`ifdef PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_baud      <= w_baud_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_txd       <= w_txd_nxt;
      r_rd        <= w_rd_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
`ifdef PARITY_EN
      r_parity    <= w_parity_nxt;
`endif
    end
  end

  // txd is registered: each branch computes the line level for the NEXT cycle,
  // so every bit boundary preloads the following bit onto the output.
  always_comb begin
    w_state_nxt     = r_state;
    w_baud_nxt      = r_baud;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_txd_nxt       = r_txd;
    w_rd_nxt        = 1'b0;
    w_frame_cnt_nxt = r_frame_cnt;
`ifdef PARITY_EN
    w_parity_nxt    = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        w_txd_nxt  = 1'b1;
        w_baud_nxt = '0;
        if (tx_en && !empty) begin
          w_state_nxt = S_REQ;
          w_rd_nxt    = 1'b1;
        end
      end

      // FIFO samples rd at the edge ending this cycle; datao is valid in WAIT.
      S_REQ: begin
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        w_shift_nxt   = fifo_data;
`ifdef PARITY_EN
        w_parity_nxt  = ^fifo_data;
`endif
        w_bit_idx_nxt = '0;
        w_baud_nxt    = '0;
        w_txd_nxt     = 1'b0;
        w_state_nxt   = S_START;
      end

      S_START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_txd_nxt   = r_shift[0];
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
          if (r_bit_idx == 3'd7) begin
`ifdef PARITY_EN
            w_txd_nxt   = r_parity;
            w_state_nxt = S_PAR;
`else
            w_txd_nxt   = 1'b1;
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_txd_nxt     = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

`ifdef PARITY_EN
      S_PAR: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_txd_nxt   = 1'b1;
          w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt      = '0;
          w_txd_nxt       = 1'b1;
          w_frame_cnt_nxt = r_frame_cnt + 8'd1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      default: begin
        w_txd_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rd        = r_rd;
  assign txd       = r_txd;
  assign busy      = (r_state != S_IDLE);
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a queue-based FIFO model and a
// cycle-level reference model of the serial frame timing.
module tb_fifo_uart_tx;

  localparam int C = 4;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FB     = NB * C + 2;  // busy cycles per frame (REQ, WAIT, bits)
  localparam int PERIOD = FB + 1;      // plus one IDLE cycle

  logic       clk = 1'b0;
  logic       res;
  logic       tx_en;
  logic       empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       rd;
  logic       txd;
  logic       busy;
  logic [7:0] frame_cnt;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(8)) dut (
    .clk       (clk),
    .res       (res),
    .tx_en     (tx_en),
    .empty     (empty),
    .fifo_data (fifo_data),
    .rd        (rd),
    .txd       (txd),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: registered datao, pop on sampled rd
  logic [7:0] fq[$];
  logic [7:0] ref_q[$];

  always @(posedge clk) begin
    if (rd && fq.size() > 0) fifo_data <= fq.pop_front();
    empty <= (fq.size() == 0);
  end

  task automatic push(input logic [7:0] d);
    fq.push_back(d);
    ref_q.push_back(d);
  endtask

  // Event counters for explicit checks
  int rd_cnt = 0, busy_cnt = 0, rd_last = 0, rd_prev = 0;
  always @(negedge clk) begin
    if (rd) begin
      rd_cnt  <= rd_cnt + 1;
      rd_prev <= rd_last;
      rd_last <= cyc;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // Reference model: a frame fetched at cycle m_rd occupies m_rd .. m_rd+FB-1,
  // line level at m_rd+2+j is frame bit j/C, count bumps at m_rd+FB.
  int          t = 0;
  bit          m_act = 0;
  bit          m_counted = 1;
  int          m_rd = 0;
  int          m_cnt = 0;
  logic [10:0] m_bits = '1;

  always @(negedge clk) begin
    int         end_c;
    bit         in_fr;
    logic       e_txd;
    logic [7:0] d;
    if (res) begin
      m_act = 0;
      m_counted = 1;
      m_cnt = 0;
      chk("rst_rd", int'(rd), 0);
      chk("rst_txd", int'(txd), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cnt", int'(frame_cnt), 0);
    end else begin
      end_c = m_rd + FB;
      if (m_act && !m_counted && t >= end_c) begin
        m_cnt = (m_cnt + 1) % 256;
        m_counted = 1;
      end
      in_fr = m_act && (t >= m_rd) && (t < end_c);
      e_txd = 1'b1;
      if (in_fr && t >= m_rd + 2) e_txd = m_bits[(t - m_rd - 2) / C];
      chk("mdl_rd", int'(rd), int'(m_act && t == m_rd));
      chk("mdl_txd", int'(txd), int'(e_txd));
      chk("mdl_busy", int'(busy), int'(in_fr));
      chk("mdl_cnt", int'(frame_cnt), m_cnt);
      if (!in_fr && tx_en && !empty) begin
        d = 8'h00;
        if (ref_q.size() > 0) d = ref_q.pop_front();
`ifdef PARITY_EN
        m_bits = {1'b1, ^d, d, 1'b0};
`else
        m_bits = {1'b1, 1'b1, d, 1'b0};
`endif
        m_rd = t + 1;
        m_act = 1;
        m_counted = 0;
      end
    end
    t = t + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sample each frame bit mid-slot, starting at the first low cycle.
  task automatic capture(output logic [10:0] got, output int fall);
    int n;
    got = '1;
    fall = -1;
    n = 0;
    @(negedge clk);
    while (txd != 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (txd != 1'b0) begin
      chk("start_timeout", int'(txd), 0);
      return;
    end
    fall = cyc;
    for (int k = 0; k < NB * C; k++) begin
      if (k > 0) @(negedge clk);
      if (k % C == C / 2) got[k / C] = txd;
    end
  endtask

  typedef struct {
    logic [7:0] din;
    logic [9:0] exp_line;  // start, d0..d7, stop (bit 0 first on the line)
    logic       exp_par;
  } vec_t;

  vec_t vt [6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] got;
    int f1, f2, r0, b0, n, exp_frames;

    vt[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
    vt[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vt[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vt[3] = '{8'h07, 10'b1_00000111_0, 1'b1};
    vt[4] = '{8'h3C, 10'b1_00111100_0, 1'b0};
    vt[5] = '{8'h80, 10'b1_10000000_0, 1'b1};

    res = 1'b0;
    tx_en = 1'b0;
    exp_frames = 0;
    #1 res = 1'b1;
    #2;
    chk("reset_txd", int'(txd), 1);
    chk("reset_rd", int'(rd), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cnt", int'(frame_cnt), 0);
    cycles(3);
    res = 1'b0;
    cycles(2);

    // Single frames from the vector table
    tx_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      r0 = rd_cnt;
      b0 = busy_cnt;
      push(vt[i].din);
      capture(got, f1);
      cycles(3);
      exp_frames++;
      chk("vec_line", int'({got[NB-1], got[8:0]}), int'(vt[i].exp_line));
`ifdef PARITY_EN
      chk("vec_parity", int'(got[9]), int'(vt[i].exp_par));
`endif
      chk("vec_rd_pulses", rd_cnt - r0, 1);
      chk("vec_busy_cycles", busy_cnt - b0, FB);
      chk("vec_frame_cnt", int'(frame_cnt), exp_frames % 256);
    end

    // Back-to-back frames
    r0 = rd_cnt;
    push(8'h00);
    push(8'hFF);
    capture(got, f1);
    chk("b2b_line0", int'({got[NB-1], got[8:0]}), int'(10'b1_00000000_0));
    capture(got, f2);
    chk("b2b_line1", int'({got[NB-1], got[8:0]}), int'(10'b1_11111111_0));
    cycles(3);
    exp_frames += 2;
    chk("b2b_start_gap", f2 - f1, NB * C + 3);
    chk("b2b_rd_gap", rd_last - rd_prev, PERIOD);
    chk("b2b_rd_pulses", rd_cnt - r0, 2);
    chk("b2b_frame_cnt", int'(frame_cnt), exp_frames % 256);

    // tx_en gating; drop during data bit 3 must not abort the frame
    tx_en = 1'b0;
    r0 = rd_cnt;
    push(8'h55);
    push(8'h3C);
    cycles(200);
    chk("gate_no_rd", rd_cnt - r0, 0);
    chk("gate_txd_idle", int'(txd), 1);
    tx_en = 1'b1;
    n = 0;
    while (rd_cnt == r0 && n < 100) begin
      cycles(1);
      n++;
    end
    chk("gate_rd_seen", rd_cnt - r0, 1);
    cycles(18);
    tx_en = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      cycles(1);
      n++;
    end
    exp_frames++;
    chk("gate_frame_done", int'(busy), 0);
    chk("gate_frame_cnt", int'(frame_cnt), exp_frames % 256);
    cycles(50);
    chk("gate_single_rd", rd_cnt - r0, 1);

    // Asynchronous reset in the middle of a data bit
    tx_en = 1'b1;
    r0 = rd_cnt;
    n = 0;
    while (rd_cnt == r0 && n < 100) begin
      cycles(1);
      n++;
    end
    cycles(2 + C + 5);
    @(posedge clk);
    #2 res = 1'b1;
    #1;
    chk("async_txd", int'(txd), 1);
    chk("async_rd", int'(rd), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_cnt", int'(frame_cnt), 0);
    cycles(2);
    res = 1'b0;
    exp_frames = 0;
    r0 = rd_cnt;
    cycles(100);
    chk("post_rst_no_rd", rd_cnt - r0, 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_txd", int'(txd), 1);
    chk("post_rst_cnt", int'(frame_cnt), 0);

    // 255 random frames, then one more to wrap the counter
    for (int i = 0; i < 255; i++) push(8'($urandom));
    n = 0;
    while (frame_cnt != 8'd255 && n < 255 * PERIOD + 200) begin
      cycles(1);
      n++;
    end
    exp_frames = 255;
    chk("wrap_pre", int'(frame_cnt), exp_frames % 256);
    push(8'($urandom));
    n = 0;
    while (!busy && n < 100) begin
      cycles(1);
      n++;
    end
    while (busy && n < 300) begin
      cycles(1);
      n++;
    end
    exp_frames++;
    chk("wrap_post", int'(frame_cnt), exp_frames % 256);

    // Random tx_en / push activity, checked cycle by cycle by the model
    for (int i = 0; i < 3000; i++) begin
      tx_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) push(8'($urandom));
      cycles(1);
    end
    tx_en = 1'b1;
    n = 0;
    while ((fq.size() > 0 || busy) && n < 200 * PERIOD) begin
      cycles(1);
      n++;
    end
    cycles(5);
    chk("drain_fifo", fq.size(), 0);
    chk("drain_ref", ref_q.size(), 0);
    chk("drain_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
